// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial
//   Digit-serial BCD subtractor computing BCD_out = BCD_n1 - BCD_n2, one decimal
//   digit per clock, least significant digit first, with a start/busy/done
//   handshake. Operands containing a nibble above 9 are rejected with err.
//
// Parameters
//   DIGITS   number of BCD digits per operand/result (buses are 4*DIGITS wide)
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   start    request, sampled only while idle
//   BCD_n1   minuend, packed BCD, most significant digit in the top nibble
//   BCD_n2   subtrahend, packed BCD
//   BCD_out  result, packed BCD, held until the next done
//   borrow   1 when BCD_n1 < BCD_n2, held with BCD_out
//   err      1 when an operand nibble is above 9, held with BCD_out
//   busy     high whenever an operation is in flight, including the done cycle
//   done     one-cycle completion pulse
//
// Optional feature (macro BCD_SUB_SIGN_MAG_EN)
//   When defined, a negative result is converted to sign-magnitude form by a
//   second digit-serial pass (0 - raw result): BCD_out = |n1 - n2| and borrow
//   is the sign. When undefined, a negative result is left as the raw ten's
//   complement and borrow marks it as negative.

module bcd_sub_serial #(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] BCD_n1,
  input  logic [4*DIGITS-1:0] BCD_n2,
  output logic [4*DIGITS-1:0] BCD_out,
  output logic                borrow,
  output logic                err,
  output logic                busy,
  output logic                done
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
`ifdef BCD_SUB_SIGN_MAG_EN
    FIX  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   res_q, res_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           brw_q, brw_d;
  logic [W-1:0]   out_q, out_d;
  logic           borrow_q, borrow_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [4:0]     diff;
  logic           dig_neg;
  logic [3:0]     dig_val;
  logic [W-1:0]   res_shift;
  logic           bad_nibble;

  // One decimal digit step on the low nibbles of the operand shift registers.
  // A negative 5-bit difference wraps to d+16 in the low nibble; adding 10
  // modulo 16 yields d+10. The new digit enters at the top of the result
  // register so that after DIGITS steps the LSD sits in the bottom nibble.
  always_comb begin
    diff      = {1'b0, opa_q[3:0]} - {1'b0, opb_q[3:0]} - {4'd0, brw_q};
    dig_neg   = diff[4];
    dig_val   = dig_neg ? diff[3:0] + 4'd10 : diff[3:0];
    res_shift = (res_q >> 4) | (W'(dig_val) << (W - 4));
  end

  // Operand validity: any nibble above 9 in either operand is rejected.
  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (BCD_n1[4*i +: 4] > 4'd9 || BCD_n2[4*i +: 4] > 4'd9) begin
        bad_nibble = 1'b1;
      end
    end
  end

  // Next-state and next-output logic. Outputs are only loaded on the edge
  // that enters DONE and otherwise hold.
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d = BCD_n1;
          opb_d = BCD_n2;
          res_d = '0;
          cnt_d = '0;
          brw_d = 1'b0;
          if (bad_nibble) begin
            state_d  = DONE;
            out_d    = '0;
            borrow_d = 1'b0;
            err_d    = 1'b1;
          end else begin
            state_d = SUB;
          end
        end
      end

      SUB: begin
        opa_d = opa_q >> 4;
        opb_d = opb_q >> 4;
        res_d = res_shift;
        brw_d = dig_neg;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_DIGIT) begin
`ifdef BCD_SUB_SIGN_MAG_EN
          if (dig_neg) begin
            // Second pass negates the raw ten's complement: 0 - raw.
            state_d = FIX;
            opa_d   = '0;
            opb_d   = res_shift;
            res_d   = '0;
            cnt_d   = '0;
            brw_d   = 1'b0;
          end else begin
            state_d  = DONE;
            out_d    = res_shift;
            borrow_d = 1'b0;
            err_d    = 1'b0;
          end
`else
          state_d  = DONE;
          out_d    = res_shift;
          borrow_d = dig_neg;
          err_d    = 1'b0;
`endif
        end
      end

`ifdef BCD_SUB_SIGN_MAG_EN
      FIX: begin
        opa_d = opa_q >> 4;
        opb_d = opb_q >> 4;
        res_d = res_shift;
        brw_d = dig_neg;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_DIGIT) begin
          state_d  = DONE;
          out_d    = res_shift;
          borrow_d = 1'b1;
          err_d    = 1'b0;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BCD_out = out_q;
  assign borrow  = borrow_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// tb_bcd_sub_serial
//   Self-checking bench for bcd_sub_serial (DIGITS=3). A behavioural model works
//   on decimal integers and predicts the held outputs and the busy/done timing;
//   a compare process checks every cycle, and directed operations pin exact
//   results and latencies with literal values.

module tb_bcd_sub_serial;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;

  logic         clk    = 1'b0;
  logic         rst    = 1'b0;
  logic         start  = 1'b0;
  logic [W-1:0] bcd_n1 = '0;
  logic [W-1:0] bcd_n2 = '0;
  logic [W-1:0] bcd_out;
  logic         borrow;
  logic         err;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  bcd_sub_serial #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .BCD_n1  (bcd_n1),
    .BCD_n2  (bcd_n2),
    .BCD_out (bcd_out),
    .borrow  (borrow),
    .err     (err),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Decimal helpers for the model.
  function automatic int bcd_value(input logic [W-1:0] v);
    int acc = 0;
    for (int i = DIGITS - 1; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
    return acc;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Expected result and latency (busy cycles) of one accepted operation.
  task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] o, output logic brw,
                          output logic er, output int lat);
    int diff;
    int modulus = 1;
    for (int i = 0; i < DIGITS; i++) modulus *= 10;
    if (has_bad(a) || has_bad(b)) begin
      o = '0; brw = 1'b0; er = 1'b1; lat = 1;
    end else begin
      diff = bcd_value(a) - bcd_value(b);
      er   = 1'b0;
      brw  = (diff < 0);
      lat  = DIGITS + 1;
      if (diff >= 0) begin
        o = to_bcd(diff);
      end else begin
`ifdef BCD_SUB_SIGN_MAG_EN
        o   = to_bcd(-diff);
        lat = 2 * DIGITS + 1;
`else
        o   = to_bcd(diff + modulus);
`endif
      end
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] r = '0;
    int sel;
    for (int i = 0; i < DIGITS; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 80)      r[4*i +: 4] = 4'($urandom_range(0, 9));
      else if (sel < 97) r[4*i +: 4] = (sel[0] ? 4'd9 : 4'd0);
      else               r[4*i +: 4] = 4'($urandom_range(10, 15));
    end
    return r;
  endfunction

  // Model state: remaining busy cycles plus held and pending outputs.
  int           m_rem = 0;
  int           p_lat = 0;
  logic [W-1:0] m_out = '0;
  logic [W-1:0] p_out = '0;
  logic         m_brw = 1'b0, m_err = 1'b0;
  logic         p_brw = 1'b0, p_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem = 0;
      m_out = '0;
      m_brw = 1'b0;
      m_err = 1'b0;
    end else begin
      if (m_rem > 0) m_rem--;
      else if (start) begin
        model_op(bcd_n1, bcd_n2, p_out, p_brw, p_err, p_lat);
        m_rem = p_lat;
      end
      if (m_rem == 1) begin
        m_out = p_out;
        m_brw = p_brw;
        m_err = p_err;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy",    {31'd0, busy},   {31'd0, m_rem > 0});
      checkOutput("done",    {31'd0, done},   {31'd0, m_rem == 1});
      checkOutput("BCD_out", {20'd0, bcd_out}, {20'd0, m_out});
      checkOutput("borrow",  {31'd0, borrow}, {31'd0, m_brw});
      checkOutput("err",     {31'd0, err},    {31'd0, m_err});
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); #1;
    bcd_n1 = a;
    bcd_n2 = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Directed operation with literal expectations; optionally pulses start
  // (with different operands) while busy and during the done cycle.
  task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_out, input logic exp_brw,
                       input logic exp_err, input int exp_lat, input bit interfere);
    int cyc = 0;
    applyStimulus(a, b);
    do begin
      @(negedge clk);
      cyc++;
      if (interfere && cyc == 1) begin
        #1; start = 1'b1; bcd_n1 = 12'h999; bcd_n2 = 12'h000;
      end
      if (interfere && cyc == 2) begin
        #1; start = 1'b0;
      end
    end while (!done && cyc < 40);
    checkOutput({name, "_done"},    {31'd0, done},    32'd1);
    checkOutput({name, "_latency"}, cyc,              exp_lat);
    checkOutput({name, "_out"},     {20'd0, bcd_out}, {20'd0, exp_out});
    checkOutput({name, "_borrow"},  {31'd0, borrow},  {31'd0, exp_brw});
    checkOutput({name, "_err"},     {31'd0, err},     {31'd0, exp_err});
    if (interfere) begin
      #1; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      repeat (3) begin
        @(negedge clk);
        checkOutput({name, "_no_extra_done"}, {31'd0, done}, 32'd0);
        checkOutput({name, "_idle"},          {31'd0, busy}, 32'd0);
      end
      checkOutput({name, "_held_out"}, {20'd0, bcd_out}, {20'd0, exp_out});
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy",   {31'd0, busy},    32'd0);
    checkOutput("reset_done",   {31'd0, done},    32'd0);
    checkOutput("reset_out",    {20'd0, bcd_out}, 32'd0);
    checkOutput("reset_borrow", {31'd0, borrow},  32'd0);
    checkOutput("reset_err",    {31'd0, err},     32'd0);
    #1 rst = 1'b0;

    $display("[TB] directed operations");
    runOp("149-089", 12'h149, 12'h089, 12'h060, 1'b0, 1'b0, 4, 1'b0);
`ifdef BCD_SUB_SIGN_MAG_EN
    runOp("089-149", 12'h089, 12'h149, 12'h060, 1'b1, 1'b0, 7, 1'b0);
`else
    runOp("089-149", 12'h089, 12'h149, 12'h940, 1'b1, 1'b0, 4, 1'b0);
`endif
    runOp("999-999", 12'h999, 12'h999, 12'h000, 1'b0, 1'b0, 4, 1'b0);
`ifdef BCD_SUB_SIGN_MAG_EN
    runOp("000-001", 12'h000, 12'h001, 12'h001, 1'b1, 1'b0, 7, 1'b0);
`else
    runOp("000-001", 12'h000, 12'h001, 12'h999, 1'b1, 1'b0, 4, 1'b0);
`endif
    runOp("bad_1A0", 12'h1A0, 12'h000, 12'h000, 1'b0, 1'b1, 1, 1'b0);
    runOp("999-000", 12'h999, 12'h000, 12'h999, 1'b0, 1'b0, 4, 1'b0);
    runOp("busy_start", 12'h149, 12'h089, 12'h060, 1'b0, 1'b0, 4, 1'b1);

    // Reset in the middle of SUB: outputs clear at once and no done follows.
    $display("[TB] reset mid-operation");
    applyStimulus(12'h500, 12'h123);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'd0, busy},    32'd0);
    checkOutput("midrst_done", {31'd0, done},    32'd0);
    checkOutput("midrst_out",  {20'd0, bcd_out}, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("midrst_no_done", {31'd0, done}, 32'd0);
    end
    runOp("500-123", 12'h500, 12'h123, 12'h377, 1'b0, 1'b0, 4, 1'b0);

    // Random traffic: start requested about a third of the cycles, including
    // while busy, with operands biased towards 0/9 digits and bad nibbles.
    $display("[TB] random traffic");
    for (int c = 0; c < 900; c++) begin
      @(negedge clk); #1;
      start  = ($urandom_range(0, 2) == 0);
      bcd_n1 = rand_operand();
      bcd_n2 = rand_operand();
    end
    @(negedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
